// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX channel among NREQ requesters, sending one byte per frame with an enforced idle gap.
// Define UART_TX_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int BYTESIZES   = 8,
  parameter int FRAME_TICKS = BYTESIZES + 3,
  parameter int GAP_TICKS   = 2
) (
  input  logic                      clock_out,
  input  logic                      nreset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*BYTESIZES-1:0] req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      tx_valid,
  output logic [BYTESIZES-1:0]      tx_data,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);

  localparam int IDW     = $clog2(NREQ);
  localparam int CNT_MAX = (FRAME_TICKS > GAP_TICKS) ? FRAME_TICKS : GAP_TICKS;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0]  FRAME_LAST = CW'(FRAME_TICKS - 1);
  localparam logic [CW-1:0]  GAP_LAST   = CW'(GAP_TICKS - 1);
  localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
  localparam logic [IDW-1:0] LAST_INIT  = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  tx_valid_n;
  logic [BYTESIZES-1:0]  tx_data_n;
  logic [IDW-1:0]        grant_n;
  logic [IDW-1:0]        last_grant, last_n;

  logic                  any_req;
  logic                  found;
  logic [IDW-1:0]        winner;
  logic [IDW-1:0]        cand;
  int                    base;
  logic [BYTESIZES-1:0]  req_bytes [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[g*BYTESIZES +: BYTESIZES];
  end

  assign any_req = |req_valid;

  // Search starts just past the last accepted requester, or at 0 in fixed-priority builds
  always_comb begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    base = 0;
`else
    base = int'(last_grant) + 1;
`endif
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((base + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // The ready strobe is gated by nreset so it stays low for the whole reset window
  always_comb begin
    req_ready = '0;
    if (nreset && (state == IDLE) && any_req) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    tx_valid_n = tx_valid;
    tx_data_n  = tx_data;
    grant_n    = grant_id;
    last_n     = last_grant;
    case (state)
      IDLE: begin
        if (any_req) begin
          tx_data_n  = req_bytes[winner];
          grant_n    = winner;
          last_n     = winner;
          tx_valid_n = 1'b1;
          cnt_n      = '0;
          state_n    = SEND;
        end
      end
      SEND: begin
        if (cnt == FRAME_LAST) begin
          tx_valid_n = 1'b0;
          cnt_n      = '0;
          state_n    = GAP;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n    = IDLE;
        cnt_n      = '0;
        tx_valid_n = 1'b0;
      end
    endcase
  end

  // Reset mid-frame drops the byte outright; nothing is kept for a retry
  always_ff @(posedge clock_out or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      cnt        <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      grant_id   <= '0;
      last_grant <= LAST_INIT;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      tx_valid   <= tx_valid_n;
      tx_data    <= tx_data_n;
      grant_id   <= grant_n;
      last_grant <= last_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a vector table for single grants plus sequences for
// held requests, late arrivals, mid-frame reset and back-to-back frames on one port.
module tb_uart_tx_arbiter;

  localparam int FRAME = 11;
  localparam int GAPT  = 2;
  localparam logic [31:0] DATA = 32'hD4C3B2A5;

  logic        clock_out;
  logic        nreset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic        busy;

  int compared;
  int mismatched;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] ready;
    logic [1:0] grant;
    logic [7:0] data;
  } vec_t;

  vec_t vecs [8];
  int   exp_seq [8];

  uart_tx_arbiter dut (
    .clock_out (clock_out),
    .nreset    (nreset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clock_out = 1'b0;
  always #5 clock_out = ~clock_out;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d);
    req_valid = v;
    req_data  = d;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic cond(input int mode);
    case (mode)
      0:       return tx_valid === 1'b1;
      1:       return tx_valid === 1'b0;
      default: return (busy === 1'b1) && (tx_valid === 1'b0);
    endcase
  endfunction

  // Counts consecutive negedges (current one included) on which the chosen condition holds
  task automatic countWhile(input int mode, input string name, output int n);
    n = 0;
    while (cond(mode) && n < 200) begin
      n++;
      @(negedge clock_out);
    end
    if (n >= 200) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s timeout: waited %0d ticks, required fewer than 200", name, n);
    end
  endtask

  task automatic doReset();
    nreset = 1'b0;
    applyStimulus(4'b1111, DATA);
    @(negedge clock_out);
    @(negedge clock_out);
    checkOutput("reset tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset tx_data", 32'(tx_data), 32'd0);
    checkOutput("reset grant_id", 32'(grant_id), 32'd0);
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);
    nreset = 1'b1;
    applyStimulus(4'b0000, DATA);
    @(negedge clock_out);
  endtask

  task automatic drainFrame();
    int n;
    req_valid = 4'b0000;
    countWhile(0, "drain high", n);
    countWhile(2, "drain gap", n);
  endtask

  initial begin
    int n;
    int bad;

    compared   = 0;
    mismatched = 0;
    nreset     = 1'b0;
    req_valid  = '0;
    req_data   = '0;

    vecs[0] = '{4'b0001, 4'b0001, 2'd0, 8'hA5};
    vecs[1] = '{4'b0110, 4'b0010, 2'd1, 8'hB2};
    vecs[2] = '{4'b0011, 4'b0001, 2'd0, 8'hA5};
    vecs[3] = '{4'b1100, 4'b0100, 2'd2, 8'hC3};
    vecs[4] = '{4'b0100, 4'b0100, 2'd2, 8'hC3};
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    vecs[5] = '{4'b1001, 4'b0001, 2'd0, 8'hA5};
    exp_seq = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    vecs[5] = '{4'b1001, 4'b1000, 2'd3, 8'hD4};
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    vecs[6] = '{4'b1111, 4'b0001, 2'd0, 8'hA5};
    vecs[7] = '{4'b0000, 4'b0000, 2'd0, 8'h00};

    doReset();

    // Table: one grant per record, each run to completion back in IDLE
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].valid, DATA);
      #1;
      checkOutput($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vecs[i].ready));
      @(negedge clock_out);
      if (vecs[i].ready == 4'b0000) begin
        checkOutput($sformatf("vec%0d idle busy", i), 32'(busy), 32'd0);
        checkOutput($sformatf("vec%0d idle tx_valid", i), 32'(tx_valid), 32'd0);
      end else begin
        checkOutput($sformatf("vec%0d tx_valid", i), 32'(tx_valid), 32'd1);
        checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'd1);
        checkOutput($sformatf("vec%0d grant_id", i), 32'(grant_id), 32'(vecs[i].grant));
        checkOutput($sformatf("vec%0d tx_data", i), 32'(tx_data), 32'(vecs[i].data));
        checkOutput($sformatf("vec%0d ready in send", i), 32'(req_ready), 32'd0);
        req_valid = 4'b0000;
        countWhile(0, "vec high", n);
        checkOutput($sformatf("vec%0d frame ticks", i), 32'(n), 32'(FRAME));
        countWhile(2, "vec gap", n);
        checkOutput($sformatf("vec%0d gap ticks", i), 32'(n), 32'(GAPT));
        checkOutput($sformatf("vec%0d idle busy", i), 32'(busy), 32'd0);
      end
      req_valid = 4'b0000;
    end

    // All four held through eight frames
    doReset();
    applyStimulus(4'b1111, DATA);
    for (int f = 0; f < 8; f++) begin
      countWhile(1, "held low", n);
      if (f > 0) checkOutput($sformatf("held%0d low ticks", f), 32'(n), 32'(GAPT + 1));
      checkOutput($sformatf("held%0d grant_id", f), 32'(grant_id), 32'(exp_seq[f]));
      countWhile(0, "held high", n);
      checkOutput($sformatf("held%0d frame ticks", f), 32'(n), 32'(FRAME));
    end
    req_valid = 4'b0000;
    countWhile(2, "held drain", n);

    // Requester 2 arrives during requester 0's frame
    doReset();
    applyStimulus(4'b0001, DATA);
    @(negedge clock_out);
    checkOutput("late first tx_valid", 32'(tx_valid), 32'd1);
    req_valid = 4'b0100;
    bad = 0;
    n   = 0;
    while (busy === 1'b1 && n < 200) begin
      if (req_ready !== 4'b0000) bad++;
      n++;
      @(negedge clock_out);
    end
    checkOutput("late ready while busy", 32'(bad), 32'd0);
    checkOutput("late busy ticks", 32'(n), 32'(FRAME + GAPT));
    checkOutput("late ready in idle", 32'(req_ready), 32'b0100);
    @(negedge clock_out);
    checkOutput("late grant_id", 32'(grant_id), 32'd2);
    checkOutput("late tx_data", 32'(tx_data), 32'hC3);
    checkOutput("late tx_valid", 32'(tx_valid), 32'd1);
    drainFrame();

    // Reset pulsed at send tick 5
    doReset();
    applyStimulus(4'b0010, DATA);
    @(negedge clock_out);
    req_valid = 4'b0000;
    checkOutput("abort tx_valid before", 32'(tx_valid), 32'd1);
    repeat (5) @(negedge clock_out);
    nreset    = 1'b0;
    req_valid = 4'b1010;
    #1;
    checkOutput("abort tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort tx_data", 32'(tx_data), 32'd0);
    checkOutput("abort ready", 32'(req_ready), 32'd0);
    @(negedge clock_out);
    nreset    = 1'b1;
    req_valid = 4'b0000;
    repeat (3) @(negedge clock_out);
    checkOutput("abort no resend tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("abort no resend busy", 32'(busy), 32'd0);
    applyStimulus(4'b1010, DATA);
    #1;
    checkOutput("abort first ready", 32'(req_ready), 32'b0010);
    @(negedge clock_out);
    checkOutput("abort first grant_id", 32'(grant_id), 32'd1);
    checkOutput("abort first tx_data", 32'(tx_data), 32'hB2);
    drainFrame();

    // Back-to-back on port 2 with a new byte queued by the requester
    doReset();
    applyStimulus(4'b0100, 32'h003C0000);
    @(negedge clock_out);
    checkOutput("b2b first tx_data", 32'(tx_data), 32'h3C);
    checkOutput("b2b first grant_id", 32'(grant_id), 32'd2);
    req_data = 32'h00C30000;
    countWhile(0, "b2b high1", n);
    checkOutput("b2b frame1 ticks", 32'(n), 32'(FRAME));
    checkOutput("b2b frozen tx_data", 32'(tx_data), 32'h3C);
    countWhile(1, "b2b low", n);
    checkOutput("b2b low ticks", 32'(n), 32'(GAPT + 1));
    checkOutput("b2b second tx_data", 32'(tx_data), 32'hC3);
    checkOutput("b2b second grant_id", 32'(grant_id), 32'd2);
    req_valid = 4'b0000;
    countWhile(0, "b2b high2", n);
    checkOutput("b2b frame2 ticks", 32'(n), 32'(FRAME));
    countWhile(2, "b2b gap2", n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
